// File: rtl/disp_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : disp_sched_pkg
// Purpose  : Shared types, constants and helpers for the display scheduler.
//            - N_SRC      : number of 16-bit word sources sharing the display
//            - state_t    : scheduler FSM states
//            - ALERT_PAT  : word shown during the "off" phase of an alert blink
//            - next_valid : round-robin search for the next valid source
// Revision : 1.0  initial release
// ============================================================================
package disp_sched_pkg;

   localparam int          N_SRC     = 4;
   localparam logic [15:0] ALERT_PAT = 16'hEEEE;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      ALERT = 2'd2
   } state_t;

   typedef struct packed {
      logic       found;
      logic [1:0] idx;
   } nv_t;

   // Search cur+1, cur+2, cur+3 (mod 4) and return the first valid index.
   // Offsets are scanned farthest-first so the nearest valid hit is written
   // last and wins. When nothing else is valid, idx stays at cur.
   function automatic nv_t next_valid(input logic [1:0]       cur,
                                      input logic [N_SRC-1:0] vld);
      nv_t        r;
      logic [1:0] idx;
      r.found = 1'b0;
      r.idx   = cur;
      for (int k = N_SRC - 1; k >= 1; k--) begin
         idx = cur + 2'(k);
         if (vld[idx]) begin
            r.found = 1'b1;
            r.idx   = idx;
         end
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/disp_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : disp_sched_if
// Purpose  : Bundles the word-source inputs, control pulses and display
//            outputs of the display scheduler.
//   ce1ms      1 ms tick from the display driver
//   src_dat    four 16-bit source words, source i at [16i+15:16i]
//   src_stb    per-source load strobe (source 0 = error word)
//   clr        invalidate all sources
//   mode_auto  1 = timed rotation, 0 = manual stepping
//   btn_next   step to the next valid source
//   dat        word to display
//   ptr_P      decimal-point digit (= current source index)
//   cur_src    current source index
//   alert_act  high while an error alert is shown
//   master : drives the inputs (stimulus side)
//   slave  : the scheduler itself
// Revision : 1.0  initial release
// ============================================================================
interface disp_sched_if;
   import disp_sched_pkg::*;

   logic                   ce1ms;
   logic [16*N_SRC-1:0]    src_dat;
   logic [N_SRC-1:0]       src_stb;
   logic                   clr;
   logic                   mode_auto;
   logic                   btn_next;
   logic [15:0]            dat;
   logic [1:0]             ptr_P;
   logic [1:0]             cur_src;
   logic                   alert_act;

   modport master (
      output ce1ms, src_dat, src_stb, clr, mode_auto, btn_next,
      input  dat, ptr_P, cur_src, alert_act
   );

   modport slave (
      input  ce1ms, src_dat, src_stb, clr, mode_auto, btn_next,
      output dat, ptr_P, cur_src, alert_act
   );

endinterface
`default_nettype wire

// File: rtl/disp_sched.sv
`default_nettype none
// ============================================================================
// Module   : disp_sched
// Purpose  : Shares one 4-digit HEX display between four 16-bit word sources.
//            Each source is latched into a shadow register; valid sources are
//            rotated on a dwell timer (or stepped by button) and a new error
//            word pre-empts the rotation with a blinking alert.
// Ports    :
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   disp   disp_sched_if.slave (ce1ms, src_dat, src_stb, clr, mode_auto,
//          btn_next in; dat, ptr_P, cur_src, alert_act out)
// Params   : DWELL_MS, ALERT_MS, BLINK_MS in 1 ms ticks
// Revision : 1.0  initial release
// ============================================================================
module disp_sched
   import disp_sched_pkg::*;
#(
   parameter int unsigned DWELL_MS = 1000,
   parameter int unsigned ALERT_MS = 3000,
   parameter int unsigned BLINK_MS = 250
) (
   input  logic         clk,
   input  logic         rst_n,
   disp_sched_if.slave  disp
);

   localparam logic [15:0] DWELL_LD = 16'(DWELL_MS);
   localparam logic [15:0] ALERT_LD = 16'(ALERT_MS);
   localparam logic [15:0] BLINK_LD = 16'(BLINK_MS);

   // Shadow registers and valid bits
   logic [N_SRC-1:0][15:0] sh_q, sh_d;
   logic [N_SRC-1:0]       vld_q, vld_d;

   // Scheduler state
   state_t      state_q, state_d;
   logic [1:0]  sel_q, sel_d;            // source being shown
   logic [15:0] dwell_q, dwell_d;
   logic [15:0] alert_cnt_q, alert_cnt_d;
   logic [15:0] blink_cnt_q, blink_cnt_d;
   logic        phase_q, phase_d;        // 1 = show error word, 0 = pattern
   logic        mode_auto_q, mode_auto_d;

   // Registered outputs
   logic [15:0] dat_q, dat_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [1:0]  cur_src_q, cur_src_d;
   logic        alert_act_q, alert_act_d;

   // Helpers
   logic        mode_rise;
   logic        dwell_exp;
   logic        step;
   logic [1:0]  lowest;
   nv_t         nv;

   // ------------------------------------------------------------------------
   // Shadow / valid update: a strobe beats clr for its own source.
   // ------------------------------------------------------------------------
   always_comb begin
      sh_d  = sh_q;
      vld_d = vld_q;
      for (int i = 0; i < N_SRC; i++) begin
         if (disp.src_stb[i]) begin
            sh_d[i]  = disp.src_dat[16*i +: 16];
            vld_d[i] = 1'b1;
         end else if (disp.clr) begin
            vld_d[i] = 1'b0;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Next-state logic. Priority: clr > error strobe > expiry / button.
   // ------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      sel_d       = sel_q;
      dwell_d     = dwell_q;
      alert_cnt_d = alert_cnt_q;
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      mode_auto_d = disp.mode_auto;

      mode_rise = disp.mode_auto & ~mode_auto_q;
      // <=1 rather than ==1 so a zero count can never stall the rotation
      dwell_exp = disp.mode_auto & disp.ce1ms & (dwell_q <= 16'd1);
      step      = disp.btn_next | dwell_exp;
      nv        = next_valid(sel_q, vld_q);
      lowest    = disp.src_stb[1] ? 2'd1 : (disp.src_stb[2] ? 2'd2 : 2'd3);

      if (disp.clr) begin
         state_d = IDLE;
         sel_d   = 2'd0;
      end else if (disp.src_stb[0]) begin
         // Entry and re-trigger look the same: restart all alert timing
         state_d     = ALERT;
         sel_d       = 2'd0;
         alert_cnt_d = ALERT_LD;
         blink_cnt_d = BLINK_LD;
         phase_d     = 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               if (|disp.src_stb[N_SRC-1:1]) begin
                  state_d = SHOW;
                  sel_d   = lowest;
                  dwell_d = DWELL_LD;
               end
            end
            SHOW: begin
               if (step) begin
                  if (nv.found) begin
                     sel_d = nv.idx;
                  end
                  dwell_d = DWELL_LD;
               end else if (mode_rise) begin
                  dwell_d = DWELL_LD;
               end else if (disp.mode_auto && disp.ce1ms) begin
                  dwell_d = dwell_q - 16'd1;
               end
            end
            ALERT: begin
               if (disp.ce1ms) begin
                  if (alert_cnt_q <= 16'd1) begin
                     // Source 0 is necessarily valid: it was strobed to get here
                     state_d = SHOW;
                     sel_d   = 2'd0;
                     dwell_d = DWELL_LD;
                  end else begin
                     alert_cnt_d = alert_cnt_q - 16'd1;
                     if (blink_cnt_q <= 16'd1) begin
                        phase_d     = ~phase_q;
                        blink_cnt_d = BLINK_LD;
                     end else begin
                        blink_cnt_d = blink_cnt_q - 16'd1;
                     end
                  end
               end
            end
            default: begin
               state_d = IDLE;
               sel_d   = 2'd0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Output stage: computed from the already-updated state, so every visible
   // change lags its cause by exactly one clock.
   // ------------------------------------------------------------------------
   always_comb begin
      dat_d       = 16'd0;
      ptr_d       = 2'd0;
      cur_src_d   = 2'd0;
      alert_act_d = 1'b0;
      case (state_q)
         SHOW: begin
            dat_d     = sh_q[sel_q];
            ptr_d     = sel_q;
            cur_src_d = sel_q;
         end
         ALERT: begin
            dat_d       = phase_q ? sh_q[0] : ALERT_PAT;
            alert_act_d = 1'b1;
         end
         default: begin
            dat_d = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_q        <= '0;
         vld_q       <= '0;
         state_q     <= IDLE;
         sel_q       <= 2'd0;
         dwell_q     <= 16'd0;
         alert_cnt_q <= 16'd0;
         blink_cnt_q <= 16'd0;
         phase_q     <= 1'b0;
         mode_auto_q <= 1'b0;
         dat_q       <= 16'd0;
         ptr_q       <= 2'd0;
         cur_src_q   <= 2'd0;
         alert_act_q <= 1'b0;
      end else begin
         sh_q        <= sh_d;
         vld_q       <= vld_d;
         state_q     <= state_d;
         sel_q       <= sel_d;
         dwell_q     <= dwell_d;
         alert_cnt_q <= alert_cnt_d;
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
         mode_auto_q <= mode_auto_d;
         dat_q       <= dat_d;
         ptr_q       <= ptr_d;
         cur_src_q   <= cur_src_d;
         alert_act_q <= alert_act_d;
      end
   end

   assign disp.dat       = dat_q;
   assign disp.ptr_P     = ptr_q;
   assign disp.cur_src   = cur_src_q;
   assign disp.alert_act = alert_act_q;

endmodule
`default_nettype wire

// File: doc/disp_sched.md
# disp_sched

Display scheduler for the 4-digit HEX display driver. It shares the single display between four 16-bit word sources (command, data, status and error words of the 1553 link). Each source latches into a shadow register. Valid sources are shown in round-robin order for a fixed dwell time, or stepped manually. A new error word pre-empts the rotation with a blinking alert. Outputs `dat`/`ptr_P` feed the display driver directly, and timing is taken from the driver's `ce1ms` tick.

## Interface
Parameters:
- `DWELL_MS`, 1000: auto-rotate dwell per source, in ms ticks (1..65535)
- `ALERT_MS`, 3000: alert pre-emption duration, in ms ticks (1..65535)
- `BLINK_MS`, 250: alert blink half-period, in ms ticks (1..ALERT_MS)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `ce1ms`  in  1  one-cycle 1 ms tick from display driver
- `src_dat`  in  64  four words; source i = bits [16i+15:16i]
- `src_stb`  in  4  one-cycle load strobe per source; source 0 = error word
- `clr`  in  1  one-cycle pulse: invalidate all sources
- `mode_auto`  in  1  level: 1 = timed rotation, 0 = manual stepping
- `btn_next`  in  1  one-cycle pulse (debounced upstream): step to next valid source
- `dat`  out  16  word to display
- `ptr_P`  out  2  decimal-point digit = current source index
- `cur_src`  out  2  current source index
- `alert_act`  out  1  high while in ALERT

## Operation
- Shadow regs `sh[0..3]` (16b) and valid bits `vld[3:0]`.
  - `src_stb[i]` loads `sh[i]` and sets `vld[i]`.
  - `clr` clears `vld` only; shadows are kept.
  - If `clr` and any `src_stb` occur in the same cycle, the strobe wins for that source.
- FSM states: IDLE, SHOW, ALERT.
- **IDLE**
  - Outputs: `dat`=0, `ptr_P`=0, `cur_src`=0.
  - Any `src_stb[i]` with i≠0 → SHOW with `cur_src`=lowest such i, dwell counter loaded with `DWELL_MS`.
  - `src_stb[0]` → ALERT.
- **SHOW**
  - Outputs: `dat`=`sh[cur_src]`, `ptr_P`=`cur_src`.
  - Auto mode: counter decrements on `ce1ms`. At 1 with `ce1ms`, step to the next valid source (cur+1, cur+2, cur+3 mod 4; the first valid one) and reload.
  - If no other source is valid, stay on the current source and reload.
  - Manual mode: counter frozen. `btn_next` performs the same step. `btn_next` in auto mode also steps and reloads.
  - A rising edge on `mode_auto` reloads the counter.
  - `clr` → IDLE.
- **ALERT**
  - Entered from any state on `src_stb[0]`, with `alert_act`=1, `cur_src`=0 and `ptr_P`=0. Alert counter is loaded with `ALERT_MS`, blink counter with `BLINK_MS`, blink phase=show.
  - Output: `dat` = `sh[0]` in the show phase, 16'hEEEE in the off phase. Phase toggles each time the blink counter expires on `ce1ms`.
  - A repeated `src_stb[0]` restarts the alert counters.
  - `btn_next` and `mode_auto` are ignored.
  - On expiry → SHOW on source 0 (valid) with dwell reloaded.
  - `clr` → IDLE.
- Priority within a cycle: `clr` > `src_stb[0]` > dwell expiry / `btn_next`.

## Timing
- Outputs are registered; all outputs reset to 0 and the FSM resets to IDLE, asynchronously on `rst_n`=0.
- Strobe at edge k: shadow/`vld` update at edge k, `dat` reflects it after edge k+1. A strobe on the displayed source is seen on the next cycle, with no state change.
- State change (tick/button/strobe) sampled at edge k: `cur_src`, `ptr_P`, `dat` and `alert_act` change after edge k+1.
- Dwell is exactly `DWELL_MS` ticks after entry, ±1 tick phase.
- Alert lasts exactly `ALERT_MS` ticks.
- Reset deassertion mid-operation restarts from IDLE with `vld`=0.

## Structure
- Package `disp_sched_pkg`:
  - `N_SRC`=4
  - state enum {IDLE, SHOW, ALERT}
  - `ALERT_PAT`=16'hEEEE
  - function `next_valid(cur, vld)` returning the next valid index and a found flag.
- Single module; no sub-module. Counters are 16 bit.

## Test plan
- **Basic rotation.** Reset, then strobe sources 1 (16'h1234) and 3 (16'hABCD) in auto mode with `DWELL_MS`=2 → `dat`=16'h1234/`ptr_P`=1, after 2 ticks 16'hABCD/`ptr_P`=3, after 2 more back to 16'h1234.
- **Manual stepping.** `mode_auto`=0 with sources 1,2 valid → no change over 10 ticks; `btn_next` → `cur_src`=2; a second `btn_next` → wraps to 1.
- **Alert pre-emption.** While showing source 2, strobe source 0 (16'hE001) with `ALERT_MS`=4, `BLINK_MS`=1 → `alert_act`=1 and `dat` alternates E001/EEEE per tick. After 4 ticks → SHOW `cur_src`=0, then next rotation → source 1 or 2.
- **Simultaneous events.** Dwell expiry and `src_stb[0]` in the same cycle → ALERT is entered. `clr` and `src_stb[0]` in the same cycle → IDLE, `dat`=0.
- **Live update and reset.** Re-strobe the displayed source with 16'h5555 → `dat`=16'h5555 two cycles later with `cur_src` unchanged. Assert `rst_n`=0 mid-ALERT → all outputs 0 immediately, IDLE after release.
